value_buffer_mp: RTL and testbench

// - Multi-port immediate/PC value store between dispatch and issue; the next generation of the dispatch-side value buffer.
// - Owns its own allocation: a free bitmap hands out entry pointers, and issued entries are recycled.
// - Adds branch-tag recovery: mispredict selectively squashes entries; branch resolve clears tag bits.
// - Dispatch writes up to NUM_WR values per cycle; issue reads up to NUM_RD values per cycle.

---
 rtl/value_buffer_mp_if.sv | 40 ++++
 rtl/value_buffer_mp.sv | 194 +++++++++++++++++++
 tb/tb_value_buffer_mp.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/value_buffer_mp_if.sv
// rtl/value_buffer_mp_if.sv - dispatch/issue bus of the multi-port value buffer
interface value_buffer_mp_if #(
  parameter int DEPTH  = 32,
  parameter int SEL    = 5,
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 3,
  parameter int TAG_W  = 5
);
  // allocation view
  logic [NUM_WR*SEL-1:0]    alloc_ptr;
  logic                     alloc_rdy;
  logic [SEL:0]             free_cnt;
  // dispatch writes
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR*TAG_W-1:0]  wr_tag;
  // issue reads
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*SEL-1:0]    rd_ptr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_vld;
  // branch recovery
  logic                     prmiss;
  logic [TAG_W-1:0]         prmiss_mask;
  logic                     prsuccess;
  logic [TAG_W-1:0]         prsuccess_tag;

  modport master (
    input  alloc_ptr, alloc_rdy, free_cnt, rd_data, rd_vld,
    output wr_en, wr_data, wr_tag, rd_en, rd_ptr,
           prmiss, prmiss_mask, prsuccess, prsuccess_tag
  );

  modport slave (
    output alloc_ptr, alloc_rdy, free_cnt, rd_data, rd_vld,
    input  wr_en, wr_data, wr_tag, rd_en, rd_ptr,
           prmiss, prmiss_mask, prsuccess, prsuccess_tag
  );
endinterface

// File: rtl/value_buffer_mp.sv
// rtl/value_buffer_mp.sv - multi-port value store with self-allocation and branch-tag squash (option: VALUE_BUFFER_BYPASS_EN)
module value_buffer_mp #(
  parameter int DEPTH  = 32,
  parameter int SEL    = 5,
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 3,
  parameter int TAG_W  = 5
) (
  input logic              clk,
  input logic              reset_n,
  value_buffer_mp_if.slave bus
);

  // state
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [SEL:0]      free_cnt_q, free_cnt_d;
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic [NUM_RD-1:0] rd_vld_q, rd_vld_d;

  // unpacked views of the bus
  logic [SEL-1:0]    alloc_ptr_c [NUM_WR];
  logic [SEL-1:0]    rd_ptr_c    [NUM_RD];
  logic [DATA_W-1:0] wr_data_c   [NUM_WR];
  logic [TAG_W-1:0]  wr_tag_c    [NUM_WR];
  logic              alloc_rdy_c;
  logic [NUM_WR-1:0] wr_act;
  logic [NUM_WR-1:0] wr_keep;
  logic [TAG_W-1:0]  succ_clr;

  // split packed bus vectors into per-port lanes
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_ptr_c[r] = bus.rd_ptr[r*SEL +: SEL];
    end
    for (int w = 0; w < NUM_WR; w++) begin
      wr_data_c[w] = bus.wr_data[w*DATA_W +: DATA_W];
      wr_tag_c[w]  = bus.wr_tag[w*TAG_W +: TAG_W];
    end
  end

  // pick the lowest NUM_WR free entries from the registered bitmap, ascending
  always_comb begin
    logic [DEPTH-1:0] avail;
    logic             found;
    avail = ~valid_q;
    found = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      alloc_ptr_c[w] = '0;
      found          = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (avail[i] && !found) begin
          found          = 1'b1;
          alloc_ptr_c[w] = SEL'(i);
        end
      end
      avail[alloc_ptr_c[w]] = 1'b0;
    end
  end

  assign alloc_rdy_c = (free_cnt_q >= (SEL+1)'(NUM_WR));

  // writes only land when a full allocation group is free and no mispredict squashes them
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_act[w] = bus.wr_en[w] & alloc_rdy_c & ~bus.prmiss;
    end
  end

  // decide whether a landing write leaves its entry valid
  always_comb begin
    wr_keep = wr_act;
`ifdef VALUE_BUFFER_BYPASS_EN
    // a same-cycle read consumes the forwarded value, so the entry is freed right away
    for (int w = 0; w < NUM_WR; w++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (bus.rd_en[r] && (rd_ptr_c[r] == alloc_ptr_c[w])) begin
          wr_keep[w] = 1'b0;
        end
      end
    end
`endif
  end

  // read results for the next cycle; idle ports hold their data
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_vld_d[r]  = 1'b0;
      rd_data_d[r] = rd_data_q[r];
      if (bus.rd_en[r]) begin
        rd_vld_d[r]  = valid_q[rd_ptr_c[r]];
        rd_data_d[r] = valid_q[rd_ptr_c[r]] ? data_q[rd_ptr_c[r]] : '0;
`ifdef VALUE_BUFFER_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_act[w] && (rd_ptr_c[r] == alloc_ptr_c[w])) begin
            rd_vld_d[r]  = 1'b1;
            rd_data_d[r] = wr_data_c[w];
          end
        end
`endif
      end
    end
  end

  // tag bit cleared by a correct resolve; mispredict overrides a resolve
  assign succ_clr = (bus.prsuccess && !bus.prmiss) ? bus.prsuccess_tag : '0;

  // next valid bitmap and tags: squash or resolve, then read frees, then writes
  always_comb begin
    logic [SEL:0] cnt;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i] & ~succ_clr;
      if (bus.prmiss && ((tag_q[i] & bus.prmiss_mask) != '0)) begin
        valid_d[i] = 1'b0;
      end
    end
    for (int r = 0; r < NUM_RD; r++) begin
      if (bus.rd_en[r]) begin
        valid_d[rd_ptr_c[r]] = 1'b0;
      end
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_act[w]) begin
        tag_d[alloc_ptr_c[w]] = wr_tag_c[w] & ~succ_clr;
        if (wr_keep[w]) begin
          valid_d[alloc_ptr_c[w]] = 1'b1;
        end
      end
    end
    cnt = (SEL+1)'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) begin
        cnt = cnt - (SEL+1)'(1);
      end
    end
    free_cnt_d = cnt;
  end

  // control state and read outputs, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      free_cnt_q <= (SEL+1)'(DEPTH);
      rd_vld_q   <= '0;
      for (int r = 0; r < NUM_RD; r++) begin
        rd_data_q[r] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      free_cnt_q <= free_cnt_d;
      rd_vld_q   <= rd_vld_d;
      for (int r = 0; r < NUM_RD; r++) begin
        rd_data_q[r] <= rd_data_d[r];
      end
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // value array has no reset; validity is tracked by valid_q
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_act[w]) begin
        data_q[alloc_ptr_c[w]] <= wr_data_c[w];
      end
    end
  end

  // repack lanes onto the bus
  always_comb begin
    bus.alloc_ptr = '0;
    bus.rd_data   = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      bus.alloc_ptr[w*SEL +: SEL] = alloc_ptr_c[w];
    end
    for (int r = 0; r < NUM_RD; r++) begin
      bus.rd_data[r*DATA_W +: DATA_W] = rd_data_q[r];
    end
  end

  assign bus.alloc_rdy = alloc_rdy_c;
  assign bus.free_cnt  = free_cnt_q;
  assign bus.rd_vld    = rd_vld_q;

endmodule

// File: tb/tb_value_buffer_mp.sv
// tb/tb_value_buffer_mp.sv - directed and random checks of value_buffer_mp against a reference model
module tb_value_buffer_mp;

`ifdef VALUE_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  value_buffer_mp_if bus ();

  value_buffer_mp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model
  bit          mvalid [32];
  logic [31:0] mdata  [32];
  logic [4:0]  mtag   [32];
  logic [31:0] erd_data [3];
  bit          erd_vld  [3];

  // stimulus for the next cycle
  bit [1:0]    wen;
  logic [31:0] wd [2];
  logic [4:0]  wt [2];
  bit [2:0]    ren;
  int          rp [3];
  bit          pm;
  logic [4:0]  pmask;
  bit          ps;
  logic [4:0]  pstag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      $error("check %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 32; i++) if (!mvalid[i]) n++;
    return n;
  endfunction

  task automatic idle();
    wen = '0; ren = '0; pm = 1'b0; ps = 1'b0; pmask = '0; pstag = '0;
    for (int k = 0; k < 2; k++) begin wd[k] = '0; wt[k] = '0; end
    for (int r = 0; r < 3; r++) rp[r] = 0;
  endtask

  task automatic drive();
    bus.wr_en         = wen;
    bus.wr_data       = {wd[1], wd[0]};
    bus.wr_tag        = {wt[1], wt[0]};
    bus.rd_en         = ren;
    bus.rd_ptr        = {5'(rp[2]), 5'(rp[1]), 5'(rp[0])};
    bus.prmiss        = pm;
    bus.prmiss_mask   = pmask;
    bus.prsuccess     = ps;
    bus.prsuccess_tag = pstag;
  endtask

  task automatic cycle();
    int  ap [2];
    int  nfree;
    int  n;
    int  hit;
    bit  rdy;
    bit  wok [2];
    bit  rd_hit;
    drive();
    #1;
    nfree = model_free();
    rdy   = (nfree >= 2);
    ap[0] = 0; ap[1] = 0; n = 0;
    for (int i = 0; i < 32; i++) begin
      if (!mvalid[i] && n < 2) begin ap[n] = i; n++; end
    end
    chk("free_cnt_pre", bus.free_cnt, nfree);
    chk("alloc_rdy", bus.alloc_rdy, rdy);
    if (rdy) begin
      chk("alloc_ptr0", bus.alloc_ptr[4:0], ap[0]);
      chk("alloc_ptr1", bus.alloc_ptr[9:5], ap[1]);
    end
    for (int k = 0; k < 2; k++) wok[k] = wen[k] && rdy && !pm;
    // expected read results from the pre-edge contents
    for (int r = 0; r < 3; r++) begin
      if (ren[r]) begin
        hit = -1;
        if (BYP) for (int k = 0; k < 2; k++) if (wok[k] && ap[k] == rp[r]) hit = k;
        if (hit >= 0) begin
          erd_vld[r]  = 1'b1;
          erd_data[r] = wd[hit];
        end else begin
          erd_vld[r]  = mvalid[rp[r]];
          erd_data[r] = mvalid[rp[r]] ? mdata[rp[r]] : 32'h0;
        end
      end else begin
        erd_vld[r] = 1'b0;
      end
    end
    // model state update
    if (pm) begin
      for (int i = 0; i < 32; i++) if ((mtag[i] & pmask) != 0) mvalid[i] = 1'b0;
    end else if (ps) begin
      for (int i = 0; i < 32; i++) mtag[i] = mtag[i] & ~pstag;
    end
    for (int r = 0; r < 3; r++) if (ren[r]) mvalid[rp[r]] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (wok[k]) begin
        mdata[ap[k]] = wd[k];
        mtag[ap[k]]  = (ps && !pm) ? (wt[k] & ~pstag) : wt[k];
        rd_hit = 1'b0;
        for (int r = 0; r < 3; r++) if (ren[r] && rp[r] == ap[k]) rd_hit = 1'b1;
        if (!(BYP && rd_hit)) mvalid[ap[k]] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("rd_vld%0d", r), bus.rd_vld[r], erd_vld[r]);
      chk($sformatf("rd_data%0d", r), bus.rd_data[r*32 +: 32], erd_data[r]);
    end
    chk("free_cnt_post", bus.free_cnt, model_free());
  endtask

  task automatic do_reset();
    idle();
    drive();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
    for (int r = 0; r < 3; r++) begin erd_vld[r] = 1'b0; erd_data[r] = '0; end
    chk("rst_free_cnt", bus.free_cnt, 32);
    chk("rst_rd_vld", bus.rd_vld, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_alloc_ptr", bus.alloc_ptr, {5'd1, 5'd0});
    chk("rst_alloc_rdy", bus.alloc_rdy, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    drive();
    #12;
    do_reset();

    // two writes into the first two entries
    idle(); wen = 2'b11; wd[0] = 32'hAAAA; wd[1] = 32'h5555;
    cycle();
    chk("dir_free30", bus.free_cnt, 30);
    chk("dir_aptr32", bus.alloc_ptr, {5'd3, 5'd2});

    // read 0,1,0 on three ports, entry 0 freed once
    idle(); ren = 3'b111; rp[0] = 0; rp[1] = 1; rp[2] = 0;
    cycle();
    chk("dir_rd0", bus.rd_data[31:0], 32'hAAAA);
    chk("dir_rd1", bus.rd_data[63:32], 32'h5555);
    chk("dir_rd2", bus.rd_data[95:64], 32'hAAAA);
    chk("dir_vld", bus.rd_vld, 3'b111);
    chk("dir_free32", bus.free_cnt, 32);

    // reset asserted right after a valid read clears outputs asynchronously
    idle(); wen = 2'b11; wd[0] = 32'h11; wd[1] = 32'h22;
    cycle();
    idle(); ren = 3'b001; rp[0] = 1;
    cycle();
    do_reset();

    // fill everything, then overflow attempt, then a single read
    for (int c = 0; c < 16; c++) begin
      idle(); wen = 2'b11; wd[0] = $urandom; wd[1] = $urandom;
      cycle();
    end
    chk("full_rdy", bus.alloc_rdy, 0);
    chk("full_free", bus.free_cnt, 0);
    idle(); wen = 2'b11; wd[0] = 32'hDEAD; wd[1] = 32'hBEEF;
    cycle();
    chk("full_ignored", bus.free_cnt, 0);
    idle(); ren = 3'b001; rp[0] = 7;
    cycle();
    chk("one_free", bus.free_cnt, 1);
    chk("one_free_rdy", bus.alloc_rdy, 0);

    // selective squash and resolve
    do_reset();
    idle(); wen = 2'b11; wd[0] = 32'h1111; wd[1] = 32'h5555; wt[0] = 5'b00010; wt[1] = 5'b00100;
    cycle();
    idle(); pm = 1'b1; pmask = 5'b00010;
    cycle();
    chk("sq_free", bus.free_cnt, 31);
    idle(); ren = 3'b001; rp[0] = 0;
    cycle();
    chk("sq_vld", bus.rd_vld[0], 0);
    chk("sq_data", bus.rd_data[31:0], 0);
    idle(); ps = 1'b1; pstag = 5'b00100;
    cycle();
    idle(); pm = 1'b1; pmask = 5'b00100; wen = 2'b01; wd[0] = 32'hBEEF;
    cycle();
    chk("surv_free", bus.free_cnt, 31);
    idle(); ren = 3'b010; rp[1] = 1;
    cycle();
    chk("surv_vld", bus.rd_vld[1], 1);
    chk("surv_data", bus.rd_data[63:32], 32'h5555);

    // write and read of the same pointer in one cycle
    do_reset();
    for (int c = 0; c < 2; c++) begin
      idle(); wen = 2'b11; wd[0] = $urandom; wd[1] = $urandom;
      cycle();
    end
    idle(); wen = 2'b01; wd[0] = 32'h1234; ren = 3'b001; rp[0] = 4;
    cycle();
    chk("byp_vld", bus.rd_vld[0], BYP);
    chk("byp_data", bus.rd_data[31:0], BYP ? 32'h1234 : 32'h0);
    chk("byp_free", bus.free_cnt, BYP ? 28 : 27);
    idle(); ren = 3'b001; rp[0] = 4;
    cycle();

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      wen = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        wd[k] = $urandom;
        wt[k] = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'(1 << $urandom_range(0, 4));
      end
      ren = 3'($urandom_range(0, 7));
      for (int r = 0; r < 3; r++) rp[r] = $urandom_range(0, 31);
      if ($urandom_range(0, 11) == 0) begin pm = 1'b1; pmask = 5'($urandom_range(1, 31)); end
      if ($urandom_range(0, 5) == 0) begin ps = 1'b1; pstag = 5'(1 << $urandom_range(0, 4)); end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
